spiflash_resp: RTL and testbench
================================

SPIFLASH_RESP -- requirements
Module: spiflash_resp

Interface
REQ-001 Parameter DEPTH, default 8: log2 of memory size in 32-bit words (byte space is 4*2^DEPTH).
REQ-002 Parameter JEDEC_ID, default 24'hEF4016: 3-byte ID returned by command 0x9F, MSB byte first.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 flash_csb  input  1  chip select from the flash controller, active-low.
REQ-006 flash_clk  input  1  SPI clock, driven from the same clk domain, sampled directly.
REQ-007 flash_io0_di  input  1  MOSI from the controller.
REQ-008 flash_io1_do  output  1  MISO data.
REQ-009 flash_io1_oe  output  1  MISO output enable.
REQ-010 ld_we  input  1  backdoor word write strobe.
REQ-011 ld_addr  input  DEPTH  backdoor word address.
REQ-012 ld_wdata  input  32  backdoor word data.

Function
REQ-013 The block SHALL register flash_clk each cycle into clk_q; rise = flash_clk & !clk_q, fall = !flash_clk & clk_q.
REQ-014 The block SHALL require flash_clk high and low phases of at least 1 clk cycle each; no other ratio is assumed.
REQ-015 The block SHALL sample flash_io0_di on a rise, MSB first.
REQ-016 The block SHALL update flash_io1_do on a fall, MSB first, taking effect in the cycle after the fall is detected.
REQ-017 The state machine SHALL have the states IDLE, CMD, ADDR, DATA and IGNORE.
REQ-018 While flash_csb=1, the state SHALL be IDLE, the bit counter SHALL be 0, and flash_io1_oe SHALL be 0.
REQ-019 Transition IDLE->CMD SHALL occur when flash_csb=0.
REQ-020 In CMD, 8 bits SHALL be shifted; the 8th rise decodes the command.
REQ-021 Command 0xAB SHALL set awake=1 and go to IGNORE.
REQ-022 Command 0xFF SHALL go to IGNORE with no state change.
REQ-023 Command 0x03 while awake SHALL go to ADDR.
REQ-024 Command 0x9F while awake SHALL go to DATA with source = JEDEC_ID.
REQ-025 Any other command, or any command while asleep (except 0xAB), SHALL go to IGNORE.
REQ-026 In ADDR, 24 bits SHALL be shifted; the 24th rise latches the byte address and enters DATA with source = memory.
REQ-027 The effective byte address SHALL be addr[DEPTH+1:0]; upper address bits are ignored.
REQ-028 On entering DATA, flash_io1_oe SHALL be set to 1.
REQ-029 DATA SHALL load the output shift register on the first fall and on every 8th fall thereafter.
REQ-030 Each memory byte load SHALL post-increment the byte address modulo 4*2^DEPTH (wrap to 0).
REQ-031 The JEDEC source SHALL return ID[23:16], ID[15:8], ID[7:0], then 0x00 repeatedly.
REQ-032 Memory byte k of word w SHALL be ld_wdata[8k+7:8k] stored at byte address 4w+k (little-endian).
REQ-033 IGNORE SHALL keep flash_io1_oe=0 until flash_csb rises.
REQ-034 flash_csb rising in any state, including mid-byte, SHALL abort the transaction; the next flash_csb low starts a fresh CMD.
REQ-035 ld_we SHALL write memory in one cycle regardless of SPI state.
REQ-036 A simultaneous ld_we and memory read of the same byte SHALL return the old data.

Reset
REQ-037 On rst=1 at a clk edge, the block SHALL set: state=IDLE, awake=0, clk_q=0, bit counter=0, shift registers=0, flash_io1_do=0, flash_io1_oe=0.
REQ-038 Reset SHALL NOT clear memory contents.
REQ-039 Reset asserted mid-transaction SHALL take priority over all SPI events; after release, the controller must raise flash_csb before the next command is decoded.

Verification
REQ-040 Scenario wake and read: ld word0=0x44332211, word1=0x88776655; send 0xAB, csb high; send 0x03 + addr 0x000000, clock 64 bits -> MISO bytes 11 22 33 44 55 66 77 88.
REQ-041 Scenario asleep after reset: send 0x03 + addr 0 -> flash_io1_oe stays 0 for the whole transaction.
REQ-042 Scenario JEDEC ID: awake, send 0x9F, clock 32 bits -> EF 40 16 00.
REQ-043 Scenario wrap: DEPTH=8, last word=0xDDCCBBAA, word0=0x44332211; read at 0x0003FF, clock 16 bits -> DD 11.
REQ-044 Scenario abort and reset: csb high after 10 address bits, then 0x03 + addr 4 -> first byte is byte 4; assert rst mid-DATA -> oe=0 next cycle, and a later 0x03 is ignored until 0xAB is sent.
REQ-045 Scenario clock ratio: repeat the REQ-040 read with flash_clk phases of 1, 2 and 5 clk cycles -> identical data.

Source files
------------

// File: rtl/spiflash_resp.sv
// SPI flash responder model: wake (0xAB), read (0x03) and JEDEC ID (0x9F).
// Word-organised backing store with a backdoor loader.
module spiflash_resp #(
  parameter int          DEPTH    = 8,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flash_csb,
  input  logic             flash_clk,
  input  logic             flash_io0_di,
  output logic             flash_io1_do,
  output logic             flash_io1_oe,
  input  logic             ld_we,
  input  logic [DEPTH-1:0] ld_addr,
  input  logic [31:0]      ld_wdata
);

  localparam int AW = DEPTH + 2;
  localparam int SW = (AW > 8) ? AW : 8;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, IGNORE
  } state_t;

  logic [31:0] mem [2**DEPTH];

  state_t          state_q, state_d;
  logic            clk_q;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [SW-2:0]   sh_q, sh_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [6:0]      sh_out_q, sh_out_d;
  logic            do_d, oe_d;
  logic            awake_q, awake_d;
  logic            src_jedec_q, src_jedec_d;
  logic [1:0]      jidx_q, jidx_d;
  logic            armed_q, armed_d;

  logic            rise, fall;
  logic [SW-1:0]   nxt;
  logic [7:0]      cmd;
  logic [31:0]     mem_word;
  logic [7:0]      mem_byte;
  logic [7:0]      jbyte;
  logic [7:0]      ld_byte;

  assign rise     = flash_clk & ~clk_q;
  assign fall     = ~flash_clk & clk_q;
  assign nxt      = {sh_q, flash_io0_di};
  assign cmd      = nxt[7:0];
  assign mem_word = mem[addr_q[AW-1:2]];
  assign mem_byte = mem_word[{addr_q[1:0], 3'b000} +: 8];
  assign ld_byte  = src_jedec_q ? jbyte : mem_byte;

  always_comb begin
    jbyte = 8'h00;
    unique case (jidx_q)
      2'd0:    jbyte = JEDEC_ID[23:16];
      2'd1:    jbyte = JEDEC_ID[15:8];
      2'd2:    jbyte = JEDEC_ID[7:0];
      default: jbyte = 8'h00;
    endcase
  end

  // Backing store: never reset; reads see pre-write data.
  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_wdata;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    addr_d      = addr_q;
    sh_out_d    = sh_out_q;
    do_d        = flash_io1_do;
    oe_d        = flash_io1_oe;
    awake_d     = awake_q;
    src_jedec_d = src_jedec_q;
    jidx_d      = jidx_q;
    armed_d     = armed_q;
    if (flash_csb) begin
      state_d   = IDLE;
      bit_cnt_d = 5'd0;
      oe_d      = 1'b0;
      armed_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          // After a reset mid-transaction, wait for a clean csb cycle.
          state_d = armed_q ? CMD : IGNORE;
          if (armed_q && rise) begin
            sh_d      = nxt[SW-2:0];
            bit_cnt_d = 5'd1;
          end
        end
        CMD: begin
          if (rise) begin
            sh_d      = nxt[SW-2:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              unique case (1'b1)
                cmd == 8'hAB: begin
                  awake_d = 1'b1;
                  state_d = IGNORE;
                end
                (cmd == 8'h03) && awake_q:
                  state_d = ADDR;
                (cmd == 8'h9F) && awake_q: begin
                  state_d     = DATA;
                  oe_d        = 1'b1;
                  src_jedec_d = 1'b1;
                  jidx_d      = 2'd0;
                end
                default:
                  state_d = IGNORE;
              endcase
            end
          end
        end
        ADDR: begin
          if (rise) begin
            sh_d      = nxt[SW-2:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d   = 5'd0;
              addr_d      = nxt[AW-1:0];
              state_d     = DATA;
              oe_d        = 1'b1;
              src_jedec_d = 1'b0;
            end
          end
        end
        DATA: begin
          if (fall) begin
            bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
            if (bit_cnt_q[2:0] == 3'd0) begin
              do_d     = ld_byte[7];
              sh_out_d = ld_byte[6:0];
              if (src_jedec_q) begin
                if (jidx_q != 2'd3) jidx_d = jidx_q + 2'd1;
              end else begin
                addr_d = addr_q + 1'b1;
              end
            end else begin
              do_d     = sh_out_q[6];
              sh_out_d = {sh_out_q[5:0], 1'b0};
            end
          end
        end
        IGNORE: oe_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      clk_q        <= 1'b0;
      bit_cnt_q    <= 5'd0;
      sh_q         <= '0;
      addr_q       <= '0;
      sh_out_q     <= 7'd0;
      flash_io1_do <= 1'b0;
      flash_io1_oe <= 1'b0;
      awake_q      <= 1'b0;
      src_jedec_q  <= 1'b0;
      jidx_q       <= 2'd0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_q        <= flash_clk;
      bit_cnt_q    <= bit_cnt_d;
      sh_q         <= sh_d;
      addr_q       <= addr_d;
      sh_out_q     <= sh_out_d;
      flash_io1_do <= do_d;
      flash_io1_oe <= oe_d;
      awake_q      <= awake_d;
      src_jedec_q  <= src_jedec_d;
      jidx_q       <= jidx_d;
      armed_q      <= armed_d;
    end
  end

endmodule

// File: tb/tb_spiflash_resp.sv
// Directed bench for spiflash_resp: wake, read, JEDEC ID,
// wrap, abort, reset and SPI clock ratio scenarios.
module tb_spiflash_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        flash_csb;
  logic        flash_clk;
  logic        flash_io0_di;
  logic        flash_io1_do;
  logic        flash_io1_oe;
  logic        ld_we;
  logic [7:0]  ld_addr;
  logic [31:0] ld_wdata;

  int checks   = 0;
  int failures = 0;
  int ph       = 1;
  logic oe_seen;

  spiflash_resp #(.DEPTH(8), .JEDEC_ID(24'hEF4016)) dut (
    .clk          (clk),
    .rst          (rst),
    .flash_csb    (flash_csb),
    .flash_clk    (flash_clk),
    .flash_io0_di (flash_io0_di),
    .flash_io1_do (flash_io1_do),
    .flash_io1_oe (flash_io1_oe),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_wdata     (ld_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    ld_we    = 1'b1;
    ld_addr  = a;
    ld_wdata = d;
    tick(1);
    ld_we    = 1'b0;
  endtask

  task automatic spi_bit(input logic tx, output logic rx);
    flash_clk    = 1'b0;
    flash_io0_di = tx;
    tick(ph);
    rx      = flash_io1_do;
    oe_seen = oe_seen | flash_io1_oe;
    flash_clk = 1'b1;
    tick(ph);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic cs_low();
    oe_seen   = 1'b0;
    flash_csb = 1'b0;
    tick(1);
  endtask

  task automatic cs_high();
    flash_clk = 1'b0;
    tick(2);
    flash_csb = 1'b1;
    tick(2);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    logic [7:0] r;
    cs_low();
    spi_byte(c, r);
    cs_high();
  endtask

  task automatic read_mem(input logic [23:0] a, input int n,
                          output logic [63:0] data);
    logic [7:0] r;
    data = '0;
    cs_low();
    spi_byte(8'h03, r);
    spi_byte(a[23:16], r);
    spi_byte(a[15:8], r);
    spi_byte(a[7:0], r);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, r);
      data = {data[55:0], r};
    end
    cs_high();
  endtask

  initial begin
    logic [63:0] d;
    logic [7:0]  r;
    logic        b;
    rst          = 1'b1;
    flash_csb    = 1'b1;
    flash_clk    = 1'b0;
    flash_io0_di = 1'b0;
    ld_we        = 1'b0;
    ld_addr      = '0;
    ld_wdata     = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_oe", {63'd0, flash_io1_oe}, 64'd0);
    check("rst_do", {63'd0, flash_io1_do}, 64'd0);

    load(8'd0,   32'h44332211);
    load(8'd1,   32'h88776655);
    load(8'd255, 32'hDDCCBBAA);

    read_mem(24'h000000, 2, d);
    check("asleep_oe", {63'd0, oe_seen}, 64'd0);

    send_cmd(8'hAB);
    read_mem(24'h000000, 8, d);
    check("read8", d, 64'h1122334455667788);
    check("read8_oe", {63'd0, oe_seen}, 64'd1);

    cs_low();
    spi_byte(8'h9F, r);
    d = '0;
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, r);
      d = {d[55:0], r};
    end
    cs_high();
    check("jedec", d, 64'h00000000EF401600);

    read_mem(24'h0003FF, 2, d);
    check("wrap", d, 64'h000000000000DD11);
    read_mem(24'hFF0005, 1, d);
    check("upper_addr", d, 64'h66);

    cs_low();
    spi_byte(8'h03, r);
    for (int i = 0; i < 10; i++) spi_bit(1'b1, b);
    cs_high();
    read_mem(24'h000004, 1, d);
    check("abort_then_read", d, 64'h55);

    ph = 2;
    read_mem(24'h000000, 8, d);
    check("ratio2", d, 64'h1122334455667788);
    ph = 5;
    read_mem(24'h000000, 8, d);
    check("ratio5", d, 64'h1122334455667788);
    ph = 1;

    cs_low();
    spi_byte(8'h03, r);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    check("pre_rst_byte", {56'd0, r}, 64'h11);
    check("pre_rst_oe", {63'd0, flash_io1_oe}, 64'd1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_oe", {63'd0, flash_io1_oe}, 64'd0);
    rst = 1'b0;
    oe_seen = 1'b0;
    spi_byte(8'h9F, r);
    spi_byte(8'h00, r);
    check("post_rst_csb_low_oe", {63'd0, oe_seen}, 64'd0);
    cs_high();
    read_mem(24'h000000, 1, d);
    check("post_rst_asleep_oe", {63'd0, oe_seen}, 64'd0);
    send_cmd(8'hAB);
    read_mem(24'h000001, 1, d);
    check("post_rst_wake_read", d, 64'h22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
